// File: rtl/fifo_word_packer.sv
// Read-side packer: pops entries from the byte FIFO, assembles PACK_COUNT lanes per word,
// and flushes a partial word with a lane mask once the input has been idle long enough.
module fifo_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             Read_Clock,
  input  logic                             Read_Reset_Enable,
  input  logic                             Empty,
  output logic                             Read_Enable,
  input  logic [DATA_WIDTH-1:0]            Fifo_Data,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] Out_Data,
  output logic [PACK_COUNT-1:0]            Out_Keep,
  output logic                             Out_Valid,
  input  logic                             Out_Ready
);

  localparam int CW = $clog2(PACK_COUNT + 1) + 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int LW = $clog2(PACK_COUNT);
  localparam logic [CW-1:0] FULL     = CW'(PACK_COUNT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

  // Output stream handshake: a word moves downstream on the cycle where
  // Out_Valid && Out_Ready; while Out_Valid && !Out_Ready the word is held.

  logic [PACK_COUNT-1:0][DATA_WIDTH-1:0] asm_q;
  logic [PACK_COUNT-1:0][DATA_WIDTH-1:0] flush_data;
  logic [PACK_COUNT-1:0]                 keep_mask;
  logic [CW-1:0]                         fill_q;
  logic [CW-1:0]                         eff_fill;
  logic [CW-1:0]                         in_flight;
  logic [LW-1:0]                         lane_idx;
  logic [IW-1:0]                         idle_q;
  logic                                  pending_q;
  logic                                  slot_free;
  logic                                  xfer_full;
  logic                                  xfer_flush;
  logic                                  transfer;
  logic                                  pop;

  assign slot_free  = !Out_Valid || Out_Ready;
  assign xfer_full  = (fill_q == FULL) && slot_free;
  assign xfer_flush = (TIMEOUT_CYCLES != 0) && (fill_q != '0) && (fill_q < FULL) &&
                      !pending_q && (idle_q == IDLE_MAX) && slot_free;
  assign transfer   = xfer_full || xfer_flush;
  assign eff_fill   = transfer ? '0 : fill_q;
  assign lane_idx   = eff_fill[LW-1:0];

  // Count the byte already in flight so a pop is only issued when its lane is guaranteed free.
  assign in_flight   = eff_fill + CW'(pending_q);
  assign Read_Enable = !Read_Reset_Enable && !Empty && (in_flight < FULL);
  assign pop         = Read_Enable && !Empty;

  always_comb begin
    flush_data = '0;
    keep_mask  = '0;
    for (int i = 0; i < PACK_COUNT; i++) begin
      if (CW'(i) < fill_q) begin
        flush_data[i] = asm_q[i];
        keep_mask[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge Read_Clock) begin
    if (Read_Reset_Enable) begin
      asm_q     <= '0;
      fill_q    <= '0;
      pending_q <= 1'b0;
      idle_q    <= '0;
      Out_Data  <= '0;
      Out_Keep  <= '0;
      Out_Valid <= 1'b0;
    end else begin
      pending_q <= pop;

      if (transfer) begin
        Out_Data  <= xfer_full ? asm_q : flush_data;
        Out_Keep  <= xfer_full ? '1 : keep_mask;
        Out_Valid <= 1'b1;
      end else if (Out_Valid && Out_Ready) begin
        Out_Valid <= 1'b0;
      end

      // A returning byte lands even in the cycle its predecessor word leaves.
      if (pending_q) begin
        asm_q[lane_idx] <= Fifo_Data;
        fill_q          <= eff_fill + CW'(1);
      end else begin
        fill_q <= eff_fill;
      end

      if (pop || pending_q || transfer) begin
        idle_q <= '0;
      end else if ((fill_q != '0) && (fill_q < FULL) && (idle_q != IDLE_MAX)) begin
        idle_q <= idle_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-based FIFO model feeds the packer, a byte-order
// scoreboard checks every accepted word, and directed scenarios check timing and masks.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PC = 4;
  localparam int TO = 16;
  localparam int OW = DW * PC;

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic          re;
  logic [DW-1:0] fdata;
  logic [OW-1:0] odata;
  logic [PC-1:0] okeep;
  logic          ovalid;
  logic          oready;

  logic          nt_empty;
  logic          nt_re;
  logic [DW-1:0] nt_fdata;
  logic [OW-1:0] nt_odata;
  logic [PC-1:0] nt_okeep;
  logic          nt_valid;
  logic          nt_ready;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_COUNT(PC), .TIMEOUT_CYCLES(TO)) dut (
    .Read_Clock(clk), .Read_Reset_Enable(rst), .Empty(empty), .Read_Enable(re),
    .Fifo_Data(fdata), .Out_Data(odata), .Out_Keep(okeep), .Out_Valid(ovalid),
    .Out_Ready(oready)
  );

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_COUNT(PC), .TIMEOUT_CYCLES(0)) dut_nt (
    .Read_Clock(clk), .Read_Reset_Enable(rst), .Empty(nt_empty), .Read_Enable(nt_re),
    .Fifo_Data(nt_fdata), .Out_Data(nt_odata), .Out_Keep(nt_okeep), .Out_Valid(nt_valid),
    .Out_Ready(nt_ready)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- FIFO models ----------------
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          force_empty = 1'b0;
  logic          pop_next = 1'b0;
  int            pop_count = 0;
  int            last_pop_cyc = 0;
  int            first_pop_cyc = -1;

  // Inputs settle at negedge+1; the pop decision for the coming edge is taken at negedge+2.
  initial begin
    empty = 1'b1;
    fdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (pop_next) fdata = fifo_q.pop_front();
      empty = force_empty || (fifo_q.size() == 0);
      #1;
      pop_next = re && !empty;
      if (pop_next) begin
        pop_count++;
        last_pop_cyc = cyc;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
  end

  logic [DW-1:0] nt_q[$];
  logic          nt_pop_next = 1'b0;
  int            nt_pops = 0;

  initial begin
    nt_empty = 1'b1;
    nt_fdata = '0;
    nt_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (nt_pop_next) nt_fdata = nt_q.pop_front();
      nt_empty = (nt_q.size() == 0);
      #1;
      nt_pop_next = nt_re && !nt_empty;
      if (nt_pop_next) nt_pops++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic clear_got();
    got_d_q.delete();
    got_k_q.delete();
    got_c_q.delete();
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (got_d_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(got_d_q.size()), 64'(n));
  endtask

  task automatic wait_pops(input int target, input string name);
    int k = 0;
    while (pop_count < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(pop_count), 64'(target));
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [OW-1:0] got_d_q[$];
  logic [PC-1:0] got_k_q[$];
  int            got_c_q[$];
  logic          held = 1'b0;
  logic [OW-1:0] held_d;
  logic [PC-1:0] held_k;
  int            stab_err = 0;
  int            re_err = 0;
  int            nt_valid_seen = 0;

  task automatic accept_word();
    int k = 0;
    logic [DW-1:0] lane;
    for (int i = 0; i < PC; i++) if (okeep[i]) k++;
    check("keep_contiguous", 64'(okeep), 64'((1 << k) - 1));
    check("keep_nonzero", 64'(k != 0), 64'd1);
    for (int i = 0; i < PC; i++) begin
      lane = odata[i*DW +: DW];
      if (i < k) begin
        if (exp_q.size() == 0) check("extra_byte", 64'(lane), 64'h1_0000_0000);
        else check("lane_byte", 64'(lane), 64'(exp_q.pop_front()));
      end else begin
        check("pad_lane_zero", 64'(lane), 64'd0);
      end
    end
    got_d_q.push_back(odata);
    got_k_q.push_back(okeep);
    got_c_q.push_back(cyc);
  endtask

  initial forever begin
    @(negedge clk);
    #3;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && (!ovalid || odata !== held_d || okeep !== held_k)) stab_err++;
      if (ovalid && oready) accept_word();
      held   = ovalid && !oready;
      held_d = odata;
      held_k = okeep;
    end
    if (re && (empty || rst)) re_err++;
    if (nt_valid) nt_valid_seen++;
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    rst    = 1'b1;
    oready = 1'b0;

    // Reset: FIFO already holds data, yet no pop may be requested.
    for (int i = 1; i <= 8; i++) push_byte(8'(i * 8'h11));
    repeat (3) @(negedge clk);
    #3;
    check("reset_out_valid", 64'(ovalid), 64'd0);
    check("reset_out_data", 64'(odata), 64'd0);
    check("reset_out_keep", 64'(okeep), 64'd0);
    check("reset_read_enable", 64'(re), 64'd0);

    // Basic pack with latency and throughput.
    @(negedge clk);
    rst = 1'b0;
    oready = 1'b1;
    first_pop_cyc = -1;
    clear_got();
    wait_words(2, 40, "basic_word_count");
    check("basic_word0", 64'(got_d_q[0]), 64'h44332211);
    check("basic_word1", 64'(got_d_q[1]), 64'h88776655);
    check("basic_keep0", 64'(got_k_q[0]), 64'hF);
    check("basic_keep1", 64'(got_k_q[1]), 64'hF);
    check("basic_latency", 64'(got_c_q[0] - first_pop_cyc), 64'(PC + 2));
    check("basic_spacing", 64'(got_c_q[1] - got_c_q[0]), 64'(PC + 1));
    repeat (30) @(negedge clk);
    check("basic_exactly_two", 64'(got_d_q.size()), 64'd2);

    // Backpressure: word 1 parked at the output, word 2 parked in assembly.
    clear_got();
    oready = 1'b0;
    p0 = pop_count;
    for (int i = 0; i < 12; i++) push_byte(8'($urandom_range(0, 255)));
    repeat (20) @(negedge clk);
    #3;
    check("bp_valid_held", 64'(ovalid), 64'd1);
    check("bp_pops_stalled", 64'(pop_count - p0), 64'(2 * PC));
    check("bp_read_enable_low", 64'(re), 64'd0);
    check("bp_nothing_accepted", 64'(got_d_q.size()), 64'd0);
    @(negedge clk);
    oready = 1'b1;
    wait_words(3, 60, "bp_word_count");
    for (int i = 0; i < 3; i++) check("bp_keep", 64'(got_k_q[i]), 64'hF);
    check("bp_stable_while_stalled", 64'(stab_err), 64'd0);
    repeat (10) @(negedge clk);

    // Timeout flush of two bytes.
    clear_got();
    p0 = pop_count;
    push_byte(8'hAA);
    push_byte(8'hBB);
    wait_pops(p0 + 2, "flush_pops");
    wait_words(1, 40, "flush_word_count");
    check("flush_data", 64'(got_d_q[0]), 64'h0000BBAA);
    check("flush_keep", 64'(got_k_q[0]), 64'h3);
    check("flush_timing", 64'(got_c_q[0] - last_pop_cyc), 64'(TO + 3));

    // A third byte at idle=10 cancels the pending flush and restarts the timeout.
    repeat (5) @(negedge clk);
    clear_got();
    p0 = pop_count;
    push_byte(8'hAA);
    push_byte(8'hBB);
    wait_pops(p0 + 2, "restart_pops");
    p0 = 0;
    while (cyc < last_pop_cyc + 12 && p0 < 40) begin
      @(negedge clk);
      p0++;
    end
    check("restart_no_early_flush", 64'(got_d_q.size()), 64'd0);
    push_byte(8'hCC);
    wait_words(1, 40, "restart_word_count");
    check("restart_data", 64'(got_d_q[0]), 64'h00CCBBAA);
    check("restart_keep", 64'(got_k_q[0]), 64'h7);
    check("restart_timing", 64'(got_c_q[0] - last_pop_cyc), 64'(TO + 3));

    // Sparse Empty: gate toggles every cycle.
    repeat (5) @(negedge clk);
    clear_got();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    for (int i = 0; i < 200 && got_d_q.size() < 4; i++) begin
      @(negedge clk);
      force_empty = ~force_empty;
    end
    @(negedge clk);
    force_empty = 1'b0;
    check("sparse_word_count", 64'(got_d_q.size()), 64'd4);
    check("sparse_word0", 64'(got_d_q[0]), 64'h03020100);
    check("sparse_word1", 64'(got_d_q[1]), 64'h07060504);
    check("sparse_word2", 64'(got_d_q[2]), 64'h0B0A0908);
    check("sparse_word3", 64'(got_d_q[3]), 64'h0F0E0D0C);
    check("sparse_no_re_when_empty", 64'(re_err), 64'd0);

    // Reset mid-word: two bytes absorbed and one in flight are discarded.
    repeat (5) @(negedge clk);
    clear_got();
    p0 = pop_count;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    wait_pops(p0 + 3, "midreset_pops");
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    wait_words(1, 40, "midreset_word_count");
    check("midreset_data", 64'(got_d_q[0]), 64'h04030201);
    check("midreset_keep", 64'(got_k_q[0]), 64'hF);
    repeat (30) @(negedge clk);
    check("midreset_exactly_one", 64'(got_d_q.size()), 64'd1);

    // Randomized traffic: random Empty gating, backpressure and idle gaps.
    clear_got();
    for (int n = 0; n < 300; ) begin
      @(negedge clk);
      oready = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        push_byte(8'($urandom_range(0, 255)));
        n++;
      end
      if ($urandom_range(0, 40) == 0) begin
        force_empty = 1'b1;
        repeat ($urandom_range(10, 30)) @(negedge clk);
      end
    end
    @(negedge clk);
    force_empty = 1'b0;
    oready = 1'b1;
    p0 = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && p0 < 500) begin
      @(negedge clk);
      p0++;
    end
    check("random_all_bytes_delivered", 64'(exp_q.size()), 64'd0);
    check("random_stability", 64'(stab_err), 64'd0);
    check("random_read_enable_rules", 64'(re_err), 64'd0);

    // Flushing disabled: a partial word stays put.
    nt_valid_seen = 0;
    for (int i = 0; i < 3; i++) nt_q.push_back(8'($urandom_range(0, 255)));
    repeat (100) @(negedge clk);
    check("notimeout_pops", 64'(nt_pops), 64'd3);
    check("notimeout_never_valid", 64'(nt_valid_seen), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Read-side consumer of the asynchronous byte FIFO. It runs in the FIFO read clock domain. It pops DATA_WIDTH-bit entries whenever the FIFO is non-empty, packs PACK_COUNT consecutive entries into one wide word, and presents that word on a valid/ready output stream. A partially filled word is flushed with a lane mask after a programmable idle timeout, so short bursts are not stranded.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry (lane width)
PACK_COUNT, 4, lanes per output word (>=2)
TIMEOUT_CYCLES, 16, idle cycles before a partial word is flushed; 0 disables flushing

Ports:
Read_Clock  input  1  single clock; same clock as the FIFO read side
Read_Reset_Enable  input  1  reset, synchronous, active-high
Empty  input  1  FIFO empty flag (combinational from FIFO)
Read_Enable  output  1  FIFO pop request; FIFO pops on Read_Enable && !Empty
Fifo_Data  input  DATA_WIDTH  FIFO Data_Out; valid the cycle after a pop
Out_Data  output  DATA_WIDTH*PACK_COUNT  packed word, lane 0 = [DATA_WIDTH-1:0] = oldest entry
Out_Keep  output  PACK_COUNT  lane-valid mask, contiguous from bit 0
Out_Valid  output  1  output word valid
Out_Ready  input  1  downstream accepts the word when Out_Valid && Out_Ready

Behaviour:
- Clock and reset: one clock, Read_Clock. Reset Read_Reset_Enable is synchronous and active-high.
- Internal state:
  - assembly register of PACK_COUNT lanes
  - fill count, 0..PACK_COUNT
  - pending flag: a pop was issued last cycle
  - output register (Out_Data/Out_Keep/Out_Valid)
  - idle counter, saturating at TIMEOUT_CYCLES
- Reset, while Read_Reset_Enable = 1:
  - Out_Valid=0, Out_Data=0, Out_Keep=0.
  - fill=0, pending=0, idle=0, assembly lanes=0.
  - Read_Enable forced 0 combinationally.
- slot_free = !Out_Valid || Out_Ready.
- transfer (full): fill==PACK_COUNT && slot_free. Actions:
  - Out_Data<=assembly, Out_Keep<=all ones, Out_Valid<=1, fill<=0.
- transfer (flush): TIMEOUT_CYCLES!=0 && 0<fill<PACK_COUNT && pending==0 && idle==TIMEOUT_CYCLES && slot_free. Actions:
  - Out_Data<=assembly with lanes >= fill zeroed.
  - Out_Keep<=(1<<fill)-1, Out_Valid<=1, fill<=0, idle<=0.
- If Out_Valid && Out_Ready and no transfer occurs, Out_Valid<=0.
- While Out_Valid && !Out_Ready, Out_Data and Out_Keep hold stable.
- eff_fill = transfer ? 0 : fill.
- Read_Enable = !Read_Reset_Enable && !Empty && (eff_fill + pending < PACK_COUNT).
  - Read_Enable is combinational.
  - It never requests while a returning byte could not be stored.
- pending <= Read_Enable && !Empty.
- Returning byte: when pending==1, Fifo_Data is written to lane eff_fill, and fill<=eff_fill+1.
  - This holds in the same cycle as a transfer; the byte lands in lane 0.
- Idle counter:
  - Cleared on any pop issue, byte arrival, or transfer.
  - Otherwise increments while 0<fill<PACK_COUNT, saturating at TIMEOUT_CYCLES.
- Flush waits (idle saturated) while the output slot is occupied.
- A byte arriving before the flush fires cancels the flush and restarts the timeout.
- Fill/pending arithmetic uses clog2(PACK_COUNT+1)+1 bits; no wrap.
- Throughput: with Empty=0 and Out_Ready=1 held, exactly PACK_COUNT entries every PACK_COUNT+1 cycles.
  - Word N+1 is valid PACK_COUNT+1 cycles after word N.
- Latency: first pop in cycle 0 -> Out_Valid rises at the edge ending cycle PACK_COUNT+1.
- Empty asserted: no pop is issued; already-pending bytes still land.
- Reset mid-operation:
  - Assembled and pending data are discarded.
  - Fifo_Data returned in the cycle after reset deasserts is ignored (pending=0).
- No data loss or duplication under any Empty/Out_Ready pattern.

Test Plan:
- Basic pack: FIFO holds 11,22,33,44,55,66,77,88; Out_Ready=1.
  -> Out_Data=32'h44332211 then 32'h88776655, Out_Keep=4'hF, valid 5 cycles apart, exactly two words.
- Backpressure: 12 bytes queued, Out_Ready=0 for 20 cycles then 1.
  -> Out_Valid high with word 1 stable throughout; Read_Enable stops after the assembly fills; all 3 words in order once released.
- Timeout flush: bytes AA,BB then Empty=1, TIMEOUT_CYCLES=16.
  -> after 16 idle cycles Out_Data=32'h0000BBAA, Out_Keep=4'b0011.
  -> a third byte arriving at idle=10 instead yields no flush at that point.
- Sparse Empty: Empty toggles every cycle over 16 bytes 00..0F.
  -> 4 words 32'h03020100..32'h0F0E0D0C; no Read_Enable while Empty=1.
- Reset mid-word: 2 bytes absorbed plus one pending, assert Read_Reset_Enable 1 cycle, then feed 01..04.
  -> next word 32'h04030201, Keep=4'hF, no stale bytes.
- TIMEOUT_CYCLES=0, 3 bytes then Empty=1 for 100 cycles -> Out_Valid stays 0.
